// File: rtl/if_fetch_queue.sv
// Fetch front end. This block owns the fetch PC and reads the combinational
// instruction ROM. Fetched {pc, instr} pairs are held in a small FIFO that feeds
// decode through a valid/ready handshake.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          IQ_DEPTH = 4,
  parameter int          ADDR_W   = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [31:0]               imem_instr,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      out_valid,
  output logic [31:0]               out_instr,
  output logic [31:0]               out_pc,
  input  logic                      out_ready,
  output logic [$clog2(IQ_DEPTH):0] iq_count
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  logic [31:0]   fetch_pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   q_instr [IQ_DEPTH];
  logic [31:0]   q_pc    [IQ_DEPTH];
  logic          pop;
  logic          push;
  logic          unused_pc_lsb;

  // The two low bits of a redirect target are ignored, because targets are word aligned.
  assign unused_pc_lsb = ^redirect_pc[1:0];

  assign imem_addr = fetch_pc[ADDR_W+1:2];
  assign iq_count  = count;
  assign out_instr = q_instr[head];
  assign out_pc    = q_pc[head];

  // A redirect hides the head in the same cycle, so that decode never consumes a wrong-path entry.
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && ((count < DEPTH_C) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail     <= tail + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The entries are cleared on reset, so the head outputs are never X while the queue is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[tail] <= imem_instr;
      q_pc[tail]    <= fetch_pc;
    end
  end

endmodule
